// File: rtl/pwm_pkg.sv
// Shared types and defaults for the multi-channel PWM generator.
package pwm_pkg;

    typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_t;
    typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_t;

    localparam int PWM_DEF_WIDTH = 11;

endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: shadow/active duty pair with boundary bypass and a
// registered strict less-than comparator against the shared counter.
module pwm_cmp_ch
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt,
    input  logic             load,
    input  logic             boundary,
    input  logic [WIDTH-1:0] duty,
    input  logic             en,
    output logic             pwm
);

    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] active;

    // Duty capture, boundary transfer (fresh load bypasses the shadow) and compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            if (load) begin
                shadow <= duty;
            end
            if (boundary) begin
                active <= load ? duty : shadow;
            end
            pwm <= en & (cnt < active);
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/center-aligned period counter, mode and
// direction control, synch pulse and period-end strobe; NCH comparators.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_DEF_WIDTH,
    parameter int NCH   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 center_mode,
    input  logic [NCH*WIDTH-1:0] duty,
    input  logic                 duty_vld,
    output logic [NCH-1:0]       PWM_sig,
    output logic                 PWM_synch,
    output logic                 period_end
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt, cnt_nxt;
    pwm_dir_t         dir, dir_nxt;
    pwm_mode_t        mode_act, mode_nxt;
    logic             boundary;
    logic             synch_nxt;
    logic             pend_nxt;

    // Counter, direction and mode state register plus registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            dir        <= DIR_UP;
            mode_act   <= PWM_EDGE;
            PWM_synch  <= 1'b0;
            period_end <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            dir        <= dir_nxt;
            mode_act   <= mode_nxt;
            PWM_synch  <= synch_nxt;
            period_end <= pend_nxt;
        end
    end

    // Next counter/direction/mode, boundary detection and strobe decode.
    always_comb begin
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        mode_nxt = mode_act;
        boundary = 1'b0;
        if (!en) begin
            // Parked: every cycle is a boundary so new duty/mode land immediately.
            boundary = 1'b1;
            cnt_nxt  = '0;
            dir_nxt  = DIR_UP;
            mode_nxt = pwm_mode_t'(center_mode);
        end else begin
            if (mode_act == PWM_EDGE) begin
                boundary = (cnt == MAX);
                cnt_nxt  = cnt + 1'b1;
                dir_nxt  = DIR_UP;
            end else begin
                boundary = (cnt == ONE) && (dir == DIR_DOWN);
                if (dir == DIR_UP) begin
                    if (cnt == MAX) begin
                        dir_nxt = DIR_DOWN;
                        cnt_nxt = cnt - 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else begin
                    if (cnt == ONE) begin
                        dir_nxt = DIR_UP;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end
            if (boundary) begin
                mode_nxt = pwm_mode_t'(center_mode);
                if (mode_nxt != mode_act) begin
                    cnt_nxt = '0;
                    dir_nxt = DIR_UP;
                end
            end
        end
        synch_nxt = en && (cnt == ONE) && (dir == DIR_UP);
        pend_nxt  = en && boundary;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_cmp_ch #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .cnt     (cnt),
            .load    (duty_vld),
            .boundary(boundary),
            .duty    (duty[i*WIDTH +: WIDTH]),
            .en      (en),
            .pwm     (PWM_sig[i])
        );
    end

endmodule
